code_converter_stream: RTL and testbench
========================================

// Module: code_converter_stream
// PURPOSE
//   Streaming, parametrised successor of the 4-bit code converter. Converts WIDTH-bit
//   words in one of four selectable codes and adds an even-parity bit.
//   Uses valid/ready handshakes on both sides and buffers results in a DEPTH-entry FIFO.
//   Sits between the input capture logic and the display/serial output stage.
//   Replaces the ready-edge-triggered, X-on-reset behaviour with defined, clocked outputs.
// PARAMETERS
//   WIDTH  4  data word width in bits (>=2)
//   DEPTH  4  output FIFO entries (power of 2, >=2)
// PORTS
//   clk        in   1                     system clock, rising edge
//   reset_n    in   1                     asynchronous active-low reset
//   flush      in   1                     synchronous FIFO clear
//   mode       in   2                     conversion select, sampled with each accepted word
//   in_data    in   WIDTH                 input word
//   in_valid   in   1                     in_data/mode valid
//   in_ready   out  1                     converter can accept a word
//   out_data   out  WIDTH                 converted word at FIFO head
//   out_parity out  1                     XOR of all out_data bits
//   out_valid  out  1                     FIFO head valid
//   out_ready  in   1                     downstream accepts head
//   level      out  $clog2(DEPTH+1)       FIFO occupancy
// BEHAVIOUR
//   Reset
//   - reset_n low (async) clears FIFO pointers and level; out_valid=0.
//   - out_data=0, out_parity=0, in_ready=0 while reset_n is low.
//   - in_ready goes high on the first clk edge after release.
//   - A reset asserted mid-transfer discards all buffered words; no partial output appears.
//   Modes (conversion is combinational on in_data; result and parity are written to the FIFO)
//   - 00 binary->Gray: g = d ^ (d>>1)
//   - 01 Gray->binary: b[W-1] = d[W-1]; b[i] = b[i+1] ^ d[i]
//   - 10 excess-3: (d + 3) mod 2^WIDTH; wraps, no carry out (4'hE -> 4'h1)
//   - 11 bit-reverse: b[i] = d[W-1-i]
//   Handshake
//   - Push on a clk edge when in_valid && in_ready.
//   - Pop on a clk edge when out_valid && out_ready.
//   - in_ready = (level < DEPTH). There is no pass-through when full, so a pop at full
//     raises in_ready only on the next cycle.
//   - out_valid = (level != 0). out_data/out_parity always show the head entry and are
//     held stable while out_valid && !out_ready.
//   - Latency: a word pushed at edge k into an empty FIFO appears with out_valid=1 after edge k (1 cycle).
//   - Simultaneous push and pop: level unchanged, both pointers advance.
//   - Pointers wrap modulo DEPTH. Words leave in FIFO order.
//   - mode may change on every word; each entry uses the mode captured with it.
//   Flush
//   - flush=1 at an edge sets level=0 and pointers=0, and ignores any push or pop at that edge.
//   - flush has priority over push and pop.
// TESTING
//   1. Reset and release: reset_n=0 -> out_valid=0, level=0, out_data=0;
//      1st edge after release -> in_ready=1.
//   2. mode=00, in 4'b0101 -> out 4'b0111, parity 1.
//      mode=01, in 4'b0111 -> out 4'b0101, parity 0.
//   3. mode=10, in 4'hE -> out 4'h1 (wrap). mode=11, in 4'b0001 -> out 4'b1000.
//   4. out_ready=0, push 5 words -> after 4th level=4, in_ready=0, 5th not accepted.
//      Then out_ready=1 -> words drain in order, level reaches 0.
//   5. level=2, push and pop in the same cycle -> level stays 2, order preserved.
//      Then flush=1 together with in_valid=1 -> level=0, out_valid=0, nothing stored.
//   6. FIFO holds 3 words; pulse reset_n low mid-cycle -> out_valid=0 immediately.
//      After release, the next pushed word is the only one output.

Source files
------------

// File: rtl/code_converter_stream.sv
// -----------------------------------------------------------------------------
// code_converter_stream
//
// Streaming code converter. Each accepted WIDTH-bit word is converted into one
// of four codes and stored in a DEPTH-entry FIFO together with an even-parity
// bit. The mode is captured with the word. Both sides use valid/ready
// handshakes.
//
// Parameters
//   WIDTH      data word width in bits (>= 2)
//   DEPTH      output FIFO entries (power of 2, >= 2)
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   flush      synchronous FIFO clear; wins over push and pop
//   mode       00 bin->Gray, 01 Gray->bin, 10 excess-3, 11 bit-reverse
//   in_data    input word
//   in_valid   in_data/mode valid
//   in_ready   converter can accept a word (FIFO not full, out of reset)
//   out_data   converted word at FIFO head (0 when empty)
//   out_parity XOR of all out_data bits (0 when empty)
//   out_valid  FIFO head valid
//   out_ready  downstream accepts head
//   level      FIFO occupancy
// -----------------------------------------------------------------------------
module code_converter_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_parity,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  // Each entry holds {parity, word}
  logic [WIDTH:0]    mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              started_q, started_d;

  logic [WIDTH-1:0]  conv_data;
  logic              conv_parity;
  logic              gray_acc;
  logic              push;
  logic              pop;
  logic [WIDTH:0]    head;

  // Conversion of the incoming word according to the mode sampled with it.
  // Gray->binary uses a running XOR from the MSB downwards.
  always_comb begin
    conv_data = '0;
    gray_acc  = 1'b0;
    case (mode)
      2'b00: conv_data = in_data ^ (in_data >> 1);
      2'b01: begin
        gray_acc           = in_data[WIDTH-1];
        conv_data[WIDTH-1] = gray_acc;
        for (int i = WIDTH - 2; i >= 0; i--) begin
          gray_acc     = gray_acc ^ in_data[i];
          conv_data[i] = gray_acc;
        end
      end
      2'b10: conv_data = in_data + WIDTH'(3);
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          conv_data[i] = in_data[WIDTH-1-i];
        end
      end
    endcase
    conv_parity = ^conv_data;
  end

  // Handshake qualifiers. in_ready is held low until the first edge after
  // reset release via started_q; a pop at full only frees space next cycle.
  always_comb begin
    in_ready  = started_q && (level_q < LW'(DEPTH));
    out_valid = (level_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next-state for pointers and level. Pointers wrap naturally because
  // DEPTH is a power of two. Flush discards any push/pop at that edge.
  always_comb begin
    started_d = 1'b1;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      started_q <= started_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible while level is nonzero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {conv_parity, conv_data};
    end
  end

  // Outputs are forced to zero when the FIFO is empty so that reset and
  // flush never expose stale storage contents.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_data   = out_valid ? head[WIDTH-1:0] : '0;
    out_parity = out_valid ? head[WIDTH] : 1'b0;
    level      = level_q;
  end

endmodule

// File: tb/tb_code_converter_stream.sv
// -----------------------------------------------------------------------------
// tb_code_converter_stream
//
// Directed testbench for code_converter_stream (WIDTH=4, DEPTH=4). Inputs are
// driven 1 time unit after a rising edge and outputs are checked at the same
// point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_code_converter_stream;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic [1:0] mode;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_parity;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;

  int compared   = 0;
  int mismatched = 0;

  code_converter_stream #(.WIDTH(4), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .mode       (mode),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, take the rising edge, settle 1 unit after it.
  task automatic applyStimulus(input logic iv, input logic [1:0] md,
                               input logic [3:0] d, input logic ordy,
                               input logic fl);
    in_valid  = iv;
    mode      = md;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    mode      = 2'b00;
    in_data   = 4'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // 1. Reset and release
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level",     32'(level),     32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    #5 reset_n = 1'b1;
    #1;
    checkOutput("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_in_ready_first_edge", 32'(in_ready), 32'd1);

    // 2./3. Each mode, one word at a time with push+pop overlap
    applyStimulus(1'b1, 2'b00, 4'b0101, 1'b0, 1'b0);
    checkOutput("gray_valid",  32'(out_valid),  32'd1);
    checkOutput("gray_data",   32'(out_data),   32'b0111);
    checkOutput("gray_parity", 32'(out_parity), 32'd1);
    applyStimulus(1'b1, 2'b01, 4'b0111, 1'b1, 1'b0);
    checkOutput("g2b_level",  32'(level),      32'd1);
    checkOutput("g2b_data",   32'(out_data),   32'b0101);
    checkOutput("g2b_parity", 32'(out_parity), 32'd0);
    applyStimulus(1'b1, 2'b10, 4'hE, 1'b1, 1'b0);
    checkOutput("xs3_data",   32'(out_data),   32'h1);
    checkOutput("xs3_parity", 32'(out_parity), 32'd1);
    applyStimulus(1'b1, 2'b11, 4'b0001, 1'b1, 1'b0);
    checkOutput("rev_data",   32'(out_data),   32'b1000);
    checkOutput("rev_parity", 32'(out_parity), 32'd1);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("drain_level", 32'(level),     32'd0);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);

    // 4. Fill to full with out_ready=0, 5th word refused, then drain in order
    applyStimulus(1'b1, 2'b11, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 4'h4, 1'b0, 1'b0);
    checkOutput("full_level",    32'(level),    32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 2'b11, 4'h5, 1'b0, 1'b0);
    checkOutput("full_5th_level", 32'(level),    32'd4);
    checkOutput("full_hold_data", 32'(out_data), 32'h8);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("pop1_data",     32'(out_data),   32'h4);
    checkOutput("pop1_parity",   32'(out_parity), 32'd1);
    checkOutput("pop1_in_ready", 32'(in_ready),   32'd1);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("pop2_data",   32'(out_data),   32'hC);
    checkOutput("pop2_parity", 32'(out_parity), 32'd0);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("pop3_data", 32'(out_data), 32'h2);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("pop4_level", 32'(level),     32'd0);
    checkOutput("pop4_valid", 32'(out_valid), 32'd0);

    // 5. Simultaneous push/pop at level 2, then flush beats a push
    applyStimulus(1'b1, 2'b10, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 4'h5, 1'b0, 1'b0);
    checkOutput("l2_level", 32'(level),    32'd2);
    checkOutput("l2_head",  32'(out_data), 32'h3);
    applyStimulus(1'b1, 2'b10, 4'h9, 1'b1, 1'b0);
    checkOutput("pp_level", 32'(level),    32'd2);
    checkOutput("pp_head",  32'(out_data), 32'h8);
    applyStimulus(1'b1, 2'b00, 4'h7, 1'b1, 1'b1);
    checkOutput("flush_level", 32'(level),     32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    checkOutput("flush_nothing_stored", 32'(level), 32'd0);

    // 6. Mid-cycle reset with 3 words buffered
    applyStimulus(1'b1, 2'b00, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 4'h3, 1'b0, 1'b0);
    checkOutput("pre_rst_level", 32'(level), 32'd3);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid",    32'(out_valid), 32'd0);
    checkOutput("mid_rst_level",    32'(level),     32'd0);
    checkOutput("mid_rst_data",     32'(out_data),  32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready),  32'd0);
    #2 reset_n = 1'b1;
    #1;
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 2'b00, 4'h4, 1'b0, 1'b0);
    checkOutput("post_rst_level", 32'(level),    32'd1);
    checkOutput("post_rst_data",  32'(out_data), 32'h6);
    applyStimulus(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("post_rst_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
